// File: rtl/mux_arbiter_4x1_if.sv
// mux_arbiter_4x1_if: request, source data, grant and output bus bundle for the operand mux arbiter.
interface mux_arbiter_4x1_if #(parameter int WIDTH = 16);
    logic [3:0]       req;
    logic [WIDTH-1:0] val1, val2, val3, val4;
    logic [3:0]       grant;
    logic [1:0]       Sel;
    logic [WIDTH-1:0] bus_out;
    logic             bus_valid;
    modport master (output req, val1, val2, val3, val4, input grant, Sel, bus_out, bus_valid);
    modport slave (input req, val1, val2, val3, val4, output grant, Sel, bus_out, bus_valid);
endinterface

// File: rtl/mux_arbiter_4x1.sv
// mux_arbiter_4x1: round-robin owner arbitration for the shared 4:1 operand mux with a registered output bus.
// Define ARB_TIMEOUT_EN to bound each ownership to MAX_HOLD cycles and mask the timed-out requester until it drops req.
module mux_arbiter_4x1 #(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 8
) (
    input logic             clk,
    input logic             rst,
    mux_arbiter_4x1_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..255");
    end

    state_t           state, state_n;
    logic [1:0]       last, last_n, win, idx, sel_n;
    logic [3:0]       elig, grant_n, mask;
    logic             found, drop, revoke;
    logic [WIDTH-1:0] word;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold, hold_n;
    logic [3:0] mask_n;
    assign revoke = state == GRANT && bus.req[last] && hold == 8'(MAX_HOLD);
`else
    assign mask   = '0;
    assign revoke = 1'b0;
`endif

    always_comb begin
        elig  = bus.req & ~mask;
        win   = last;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        drop    = !bus.req[last] || revoke;
        state_n = state;
        grant_n = bus.grant;
        sel_n   = bus.Sel;
        last_n  = last;
        if (state == IDLE) begin
            if (found) begin
                state_n = GRANT;
                grant_n = 4'b0001 << win;
                sel_n   = win;
                last_n  = win;
            end
        end else if (drop) begin
            state_n = IDLE;
            grant_n = '0;
        end
        word = bus.Sel == 2'd0 ? bus.val1 :
               bus.Sel == 2'd1 ? bus.val2 :
               bus.Sel == 2'd2 ? bus.val3 : bus.val4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last          <= 2'd3;
            bus.grant     <= '0;
            bus.Sel       <= '0;
            bus.bus_out   <= '0;
            bus.bus_valid <= 1'b0;
        end else begin
            state         <= state_n;
            last          <= last_n;
            bus.grant     <= grant_n;
            bus.Sel       <= sel_n;
            bus.bus_out   <= word;
            bus.bus_valid <= |bus.grant;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Mask bits clear as soon as their req is seen low; the owner is masked only on a forced revoke.
    always_comb begin
        hold_n = state == IDLE ? (found ? 8'd1 : hold) : (drop ? hold : hold + 8'd1);
        mask_n = (mask & bus.req) | (revoke ? bus.grant : 4'b0000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
            mask <= '0;
        end else begin
            hold <= hold_n;
            mask <= mask_n;
        end
    end
`endif
endmodule

// File: tb/tb_mux_arbiter_4x1.sv
// tb_mux_arbiter_4x1: directed and randomized checks of mux_arbiter_4x1 against a behavioural owner/queue model.
module tb_mux_arbiter_4x1;
    localparam int MH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] v [4];
    int          checks = 0;
    int          errors = 0;

    int          m_owner, m_last, m_sel, m_hold;
    logic [3:0]  m_mask;
    logic [15:0] m_bus;
    logic        m_valid;

    mux_arbiter_4x1_if #(.WIDTH(16)) bus ();

    mux_arbiter_4x1 #(.WIDTH(16), .MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.val1 = v[0];
    assign bus.val2 = v[1];
    assign bus.val3 = v[2];
    assign bus.val4 = v[3];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_sel   = 0;
        m_hold  = 0;
        m_mask  = '0;
        m_bus   = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        logic [3:0] nmask;
        nmask   = m_mask & r;
        m_bus   = v[m_sel];
        m_valid = m_owner >= 0;
        if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int i;
                i = (m_last + k) % 4;
                if (r[i] && !m_mask[i]) begin
                    m_owner = i;
                    m_sel   = i;
                    m_last  = i;
                    m_hold  = 1;
                    break;
                end
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_hold == MH) begin
            nmask[m_owner] = 1'b1;
            m_owner = -1;
        end else begin
            m_hold++;
        end
`endif
        m_mask = nmask;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".grant"}, 32'(bus.grant), m_owner < 0 ? 0 : (1 << m_owner));
        chk({tag, ".sel"}, 32'(bus.Sel), 32'(m_sel));
        chk({tag, ".bus_out"}, 32'(bus.bus_out), 32'(m_bus));
        chk({tag, ".bus_valid"}, 32'(bus.bus_valid), 32'(m_valid));
    endtask

    task automatic step(input logic [3:0] r, input string tag);
        bus.req = r;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(r);
        #1 cmp_model(tag);
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst = 1'b1;
        step(r, "reset");
        chk("reset.grant", 32'(bus.grant), 0);
        chk("reset.sel", 32'(bus.Sel), 0);
        chk("reset.bus_out", 32'(bus.bus_out), 0);
        chk("reset.bus_valid", 32'(bus.bus_valid), 0);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] r;
        v[0] = 16'h000F; v[1] = 16'h00F0; v[2] = 16'h0F00; v[3] = 16'hF000;
        bus.req = '0;
        model_reset();
        #1 do_reset(4'b0000);

        step(4'b0100, "single");
        chk("single.grant", 32'(bus.grant), 32'h4);
        chk("single.sel", 32'(bus.Sel), 2);
        for (int n = 0; n < 4; n++) begin
            step(4'b0100, "single_hold");
            chk("single.bus_out", 32'(bus.bus_out), 32'h0F00);
            chk("single.bus_valid", 32'(bus.bus_valid), 1);
        end
        step(4'b0000, "single_rel");
        chk("single_rel.grant", 32'(bus.grant), 0);
        step(4'b0000, "single_idle");
        chk("single_idle.bus_valid", 32'(bus.bus_valid), 0);

        do_reset(4'b0000);
        for (int n = 0; n < 5; n++) begin
            step(4'b1111, "rr_grant");
            chk("rr.grant", 32'(bus.grant), 1 << (n % 4));
            step(4'b1111, "rr_hold");
            chk("rr.bus_out", 32'(bus.bus_out), 32'(v[n % 4]));
            step(4'b1111 & ~(4'b0001 << (n % 4)), "rr_rel");
            chk("rr.turnaround", 32'(bus.grant), 0);
        end

        do_reset(4'b0000);
        step(4'b1000, "nopre");
        chk("nopre.own", 32'(bus.grant), 32'h8);
        for (int n = 0; n < 3; n++) begin
            step(4'b1001, "nopre_hold");
            chk("nopre.hold", 32'(bus.grant), 32'h8);
        end
        step(4'b0001, "nopre_rel");
        chk("nopre.rel", 32'(bus.grant), 0);
        step(4'b0001, "nopre_next");
        chk("nopre.next", 32'(bus.grant), 32'h1);

        step(4'b0000, "mid_rel");
        step(4'b0100, "mid_own");
        chk("mid.own", 32'(bus.grant), 32'h4);
        step(4'b0100, "mid_hold");
        do_reset(4'b0100);
        step(4'b0110, "mid_after");
        chk("mid.after", 32'(bus.grant), 32'h2);

`ifdef ARB_TIMEOUT_EN
        do_reset(4'b0000);
        for (int n = 0; n < MH; n++) begin
            step(4'b0011, "to_own0");
            chk("to.own0", 32'(bus.grant), 32'h1);
        end
        step(4'b0011, "to_revoke0");
        chk("to.revoke0", 32'(bus.grant), 0);
        for (int n = 0; n < MH; n++) begin
            step(4'b0011, "to_own1");
            chk("to.own1", 32'(bus.grant), 32'h2);
        end
        step(4'b0011, "to_revoke1");
        step(4'b0011, "to_masked");
        chk("to.masked", 32'(bus.grant), 0);
        step(4'b0010, "to_drop0");
        step(4'b0011, "to_regrant");
        chk("to.regrant", 32'(bus.grant), 32'h1);
`endif

        do_reset(4'b0000);
        r = '0;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 4; b++) begin
                v[b] = 16'($urandom);
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            rst = $urandom_range(0, 99) == 0;
            step(r, "rand");
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
